// File: rtl/clock_time_editor.sv
// Time-of-day counter (hh:mm:ss) with a debounced 5-button digit editor and registered BCD output.
// Defining CTE_ALARM_EN adds an alarm register, the AEDIT state and the alarm_hit pulse.
module clock_time_editor #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned DEB_CYC    = 1_000_000,
   parameter int unsigned REPEAT_DLY = 50,
   parameter int unsigned REPEAT_PER = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  btn,
   input  logic        mode12,
   output logic [23:0] bcd_time,
   output logic        pm,
   output logic        edit,
   output logic [5:0]  field_sel,
   output logic        tick_1hz,
   output logic        alarm_hit
);

   typedef enum logic [1:0] {StRun, StEdit, StAedit} state_e;

   typedef struct packed {
      logic [4:0] hr;
      logic [5:0] mn;
      logic [5:0] sc;
   } hms_t;

   localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned DebW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam int unsigned DlyW = $clog2(REPEAT_DLY + 1);
   localparam int unsigned PerW = (REPEAT_PER > 1) ? $clog2(REPEAT_PER) : 1;

   localparam logic [PreW-1:0] PreLast = PreW'(CLK_HZ - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYC - 1);
   localparam logic [DlyW-1:0] DlyLast = DlyW'(REPEAT_DLY - 1);
   localparam logic [DlyW-1:0] DlyFull = DlyW'(REPEAT_DLY);
   localparam logic [PerW-1:0] PerLast = PerW'(REPEAT_PER - 1);

   localparam int BtnRight = 0;
   localparam int BtnDown  = 1;
   localparam int BtnMid   = 2;
   localparam int BtnLeft  = 3;
   localparam int BtnUp    = 4;

   function automatic hms_t inc_second(input hms_t t);
      hms_t r;
      r = t;
      if (t.sc != 6'd59) begin
         r.sc = t.sc + 6'd1;
      end else begin
         r.sc = 6'd0;
         if (t.mn != 6'd59) begin
            r.mn = t.mn + 6'd1;
         end else begin
            r.mn = 6'd0;
            r.hr = (t.hr == 5'd23) ? 5'd0 : t.hr + 5'd1;
         end
      end
      return r;
   endfunction

   // Signed working copies so a borrow can go below zero before being folded back.
   function automatic hms_t adjust(input hms_t t, input logic [5:0] fsel, input logic up);
      hms_t             r;
      logic signed [7:0] s, m, h, d;
      logic             unit;
      s    = $signed({2'b00, t.sc});
      m    = $signed({2'b00, t.mn});
      h    = $signed({3'b000, t.hr});
      unit = fsel[0] | fsel[2] | fsel[4];
      d    = unit ? 8'sd1 : 8'sd10;
      if (!up) begin
         d = -d;
      end
      if (fsel[5]) begin
         h = h + (up ? 8'sd10 : 8'sd14);
      end else if (fsel[4]) begin
         h = h + d;
      end else begin
         if (fsel[2] | fsel[3]) begin
            m = m + d;
         end else if (fsel[0] | fsel[1]) begin
            s = s + d;
            if (s > 8'sd59) begin
               s = s - 8'sd60;
               m = m + 8'sd1;
            end else if (s < 8'sd0) begin
               s = s + 8'sd60;
               m = m - 8'sd1;
            end
         end
         if (m > 8'sd59) begin
            m = m - 8'sd60;
            h = h + 8'sd1;
         end else if (m < 8'sd0) begin
            m = m + 8'sd60;
            h = h - 8'sd1;
         end
      end
      if (h > 8'sd23) begin
         h = h - 8'sd24;
      end else if (h < 8'sd0) begin
         h = h + 8'sd24;
      end
      r.hr = h[4:0];
      r.mn = m[5:0];
      r.sc = s[5:0];
      return r;
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] tens;
      logic [5:0] rem;
      tens = 4'd0;
      rem  = v;
      for (int i = 0; i < 6; i++) begin
         if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, rem[3:0]};
   endfunction

   // Button synchroniser and sampled debounce
   logic [4:0]      btn_meta_q, btn_sync_q, btn_cur_q, rise_q;
   logic [DebW-1:0] deb_cnt_q;
   logic            sample_q;
   logic [4:0]      rise_raw;
   logic            multi_rise;

   always_comb begin
      rise_raw   = btn_sync_q & ~btn_cur_q;
      multi_rise = (rise_raw & (rise_raw - 5'd1)) != 5'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta_q <= '0;
         btn_sync_q <= '0;
         btn_cur_q  <= '0;
         rise_q     <= '0;
         deb_cnt_q  <= '0;
         sample_q   <= 1'b0;
      end else begin
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
         sample_q   <= 1'b0;
         rise_q     <= '0;
         if (deb_cnt_q == DebLast) begin
            deb_cnt_q <= '0;
            btn_cur_q <= btn_sync_q;
            sample_q  <= 1'b1;
            rise_q    <= multi_rise ? 5'd0 : rise_raw;
         end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end
      end
   end

   // Main state
   state_e          state_q;
   hms_t            time_q;
   logic [PreW-1:0] pre_q;
   logic [5:0]      field_q;
   logic            edit_q, tick_q;
   logic [DlyW-1:0] dly_q;
   logic [PerW-1:0] per_q;

   logic counting, pre_wrap, in_edit, held_up, held_dn, rep_keep, rep_fire, step_req, step_up;
   hms_t time_inc, edit_src, edit_res;

`ifdef CTE_ALARM_EN
   hms_t alarm_q;
   logic armed_q, alarm_hit_q;
`endif

   always_comb begin
      counting = (state_q != StEdit);
      pre_wrap = counting && (pre_q == PreLast);
      in_edit  = (state_q != StRun);
      held_up  = btn_cur_q[BtnUp] && !btn_cur_q[BtnDown];
      held_dn  = btn_cur_q[BtnDown] && !btn_cur_q[BtnUp];
      rep_keep = (rise_q == 5'd0) && (held_up || held_dn);
      rep_fire = in_edit && sample_q && rep_keep &&
                 ((dly_q == DlyLast) || ((dly_q == DlyFull) && (per_q == PerLast)));
      step_req = in_edit && (rise_q[BtnUp] || rise_q[BtnDown] || rep_fire);
      step_up  = rise_q[BtnUp] || (rep_fire && held_up);
      time_inc = inc_second(time_q);
`ifdef CTE_ALARM_EN
      edit_src = (state_q == StAedit) ? alarm_q : time_q;
`else
      edit_src = time_q;
`endif
      edit_res = adjust(edit_src, field_q, step_up);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
         time_q  <= '0;
         pre_q   <= '0;
         field_q <= 6'b000001;
         edit_q  <= 1'b0;
         tick_q  <= 1'b0;
         dly_q   <= '0;
         per_q   <= '0;
`ifdef CTE_ALARM_EN
         alarm_q     <= '0;
         armed_q     <= 1'b0;
         alarm_hit_q <= 1'b0;
`endif
      end else begin
         tick_q <= pre_wrap;
         if (!counting || pre_wrap) begin
            pre_q <= '0;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
         if (pre_wrap) begin
            time_q <= time_inc;
         end
`ifdef CTE_ALARM_EN
         alarm_hit_q <= armed_q && (state_q == StRun) && pre_wrap && (time_inc == alarm_q);
`endif
         // Auto-repeat: REPEAT_DLY held samples to the first repeat, then one every REPEAT_PER
         if (!in_edit || (sample_q && !rep_keep)) begin
            dly_q <= '0;
            per_q <= '0;
         end else if (sample_q) begin
            if (dly_q != DlyFull) begin
               dly_q <= dly_q + 1'b1;
            end else if (per_q == PerLast) begin
               per_q <= '0;
            end else begin
               per_q <= per_q + 1'b1;
            end
         end
         unique case (state_q)
            StRun: begin
               if (rise_q[BtnMid]) begin
                  state_q <= StEdit;
                  edit_q  <= 1'b1;
                  field_q <= 6'b000001;
                  pre_q   <= '0;
               end
            end
            StEdit: begin
               if (step_req) begin
                  time_q <= edit_res;
               end
               if (rise_q[BtnMid]) begin
`ifdef CTE_ALARM_EN
                  state_q <= StAedit;
                  field_q <= 6'b000001;
`else
                  state_q <= StRun;
                  edit_q  <= 1'b0;
`endif
               end else if (rise_q[BtnLeft]) begin
                  field_q <= {field_q[4:0], field_q[5]};
               end else if (rise_q[BtnRight]) begin
                  field_q <= {field_q[0], field_q[5:1]};
               end
            end
`ifdef CTE_ALARM_EN
            StAedit: begin
               if (step_req) begin
                  alarm_q <= edit_res;
               end
               if (rise_q[BtnMid]) begin
                  state_q <= StRun;
                  edit_q  <= 1'b0;
                  armed_q <= 1'b1;
               end else if (rise_q[BtnLeft]) begin
                  field_q <= {field_q[4:0], field_q[5]};
               end else if (rise_q[BtnRight]) begin
                  field_q <= {field_q[0], field_q[5:1]};
               end
            end
`endif
            default: state_q <= StRun;
         endcase
      end
   end

   // Display path: 12 h mapping is cosmetic, internal hours stay 0..23
   hms_t        disp;
   logic [4:0]  disp_hr;
   logic        pm_d;
   logic [23:0] bcd_q;
   logic        pm_q;

   always_comb begin
`ifdef CTE_ALARM_EN
      disp = (state_q == StAedit) ? alarm_q : time_q;
`else
      disp = time_q;
`endif
      disp_hr = disp.hr;
      if (mode12) begin
         if (disp.hr == 5'd0) begin
            disp_hr = 5'd12;
         end else if (disp.hr > 5'd12) begin
            disp_hr = disp.hr - 5'd12;
         end
      end
      pm_d = mode12 && (disp.hr >= 5'd12);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_q <= '0;
         pm_q  <= 1'b0;
      end else begin
         bcd_q <= {to_bcd({1'b0, disp_hr}), to_bcd(disp.mn), to_bcd(disp.sc)};
         pm_q  <= pm_d;
      end
   end

   assign bcd_time  = bcd_q;
   assign pm        = pm_q;
   assign edit      = edit_q;
   assign field_sel = field_q;
   assign tick_1hz  = tick_q;
`ifdef CTE_ALARM_EN
   assign alarm_hit = alarm_hit_q;
`else
   assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_editor.sv
// Self-checking bench for clock_time_editor (default build): directed steps plus random edits
// checked against a seconds-of-day reference model.
module tb_clock_time_editor;

   localparam int unsigned ClkHz  = 20;
   localparam int unsigned DebCyc = 4;
   localparam int DaySec = 86400;
   localparam logic [4:0] BUp = 5'b10000, BLeft = 5'b01000, BMid = 5'b00100,
                          BDown = 5'b00010, BRight = 5'b00001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  btn = '0;
   logic        mode12 = 1'b0;
   logic [23:0] bcd_time;
   logic        pm, edit, tick_1hz, alarm_hit;
   logic [5:0]  field_sel;

   int checks = 0;
   int errors = 0;
   int tick_total = 0;
   int m_t = 0;
   int m_f = 0;

   clock_time_editor #(
      .CLK_HZ    (ClkHz),
      .DEB_CYC   (DebCyc),
      .REPEAT_DLY(50),
      .REPEAT_PER(10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .mode12   (mode12),
      .bcd_time (bcd_time),
      .pm       (pm),
      .edit     (edit),
      .field_sel(field_sel),
      .tick_1hz (tick_1hz),
      .alarm_hit(alarm_hit)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_1hz) tick_total <= tick_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_bcd(input int t, input logic m12);
      int h, m, s, hd;
      h  = t / 3600;
      m  = (t / 60) % 60;
      s  = t % 60;
      hd = h;
      if (m12) begin
         if (h == 0) hd = 12;
         else if (h > 12) hd = h - 12;
      end
      return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_disp(input string tag);
      check({tag, "_bcd"}, 32'(bcd_time), 32'(exp_bcd(m_t, mode12)));
      check({tag, "_pm"}, 32'(pm), 32'(mode12 && (m_t / 3600 >= 12)));
      check({tag, "_field"}, 32'(field_sel), 32'(1 << m_f));
   endtask

   task automatic do_reset();
      btn = '0;
      rst = 1'b0;
      clks(3);
      rst = 1'b1;
      m_t = 0;
      m_f = 0;
   endtask

   task automatic press(input logic [4:0] mask);
      btn = mask;
      clks(12);
      btn = '0;
      clks(12);
   endtask

   // Leave EDIT and stop 22 clks after the press, before the first second can elapse.
   task automatic exit_press();
      btn = BMid;
      clks(12);
      btn = '0;
      clks(10);
   endtask

   task automatic model_adj(input bit up);
      int d, h;
      case (m_f)
         0: d = 1;
         1: d = 10;
         2: d = 60;
         3: d = 600;
         4: d = 3600;
         default: d = 0;
      endcase
      if (m_f == 5) begin
         h   = (m_t / 3600 + (up ? 10 : 14)) % 24;
         m_t = h * 3600 + m_t % 3600;
      end else begin
         m_t = (m_t + (up ? d : -d) + DaySec) % DaySec;
      end
   endtask

   initial begin
      int snap;
      int op;

      // Reset values and one minute of free running
      btn = '0;
      rst = 1'b0;
      clks(3);
      check("rst_bcd", 32'(bcd_time), 32'h0);
      check("rst_edit", 32'(edit), 32'h0);
      check("rst_field", 32'(field_sel), 32'h1);
      check("rst_tick", 32'(tick_1hz), 32'h0);
      check("rst_alarm", 32'(alarm_hit), 32'h0);
      rst  = 1'b1;
      snap = tick_total;
      clks(60 * ClkHz + 2);
      m_t = 60;
      check_disp("t1");
      check("t1_ticks", 32'(tick_total - snap), 32'd60);

      // Preload 23:59:59, return to RUN, one second wraps the day
      do_reset();
      press(BMid);
      check("t2_edit", 32'(edit), 32'h1);
      press(BDown);
      model_adj(1'b0);
      check_disp("t2_pre");
      exit_press();
      check_disp("t2_hold");
      check("t2_run", 32'(edit), 32'h0);
      clks(ClkHz);
      m_t = (m_t + 1) % DaySec;
      check_disp("t2_wrap");

      // Tens-of-seconds carry and borrow
      do_reset();
      press(BMid);
      press(BLeft);
      m_f = 1;
      repeat (4) begin
         press(BUp);
         model_adj(1'b1);
      end
      press(BUp);
      model_adj(1'b1);
      check_disp("t3_s50");
      press(BUp);
      model_adj(1'b1);
      check_disp("t3_carry");
      do_reset();
      press(BMid);
      repeat (5) begin
         press(BUp);
         model_adj(1'b1);
      end
      press(BLeft);
      m_f = 1;
      press(BDown);
      model_adj(1'b0);
      check_disp("t3_borrow");

      // Simultaneous rises are rejected
      press(BUp | BLeft);
      check_disp("t4_multi");

      // Held up: one step on the rise plus three repeats
      do_reset();
      press(BMid);
      btn = BUp;
      clks(302);
      btn = '0;
      clks(12);
      repeat (4) model_adj(1'b1);
      check_disp("t5_repeat");
      btn = BUp;
      clks(240);
      rst = 1'b0;
      clks(2);
      check("t5_rst_bcd", 32'(bcd_time), 32'h0);
      check("t5_rst_edit", 32'(edit), 32'h0);
      check("t5_rst_field", 32'(field_sel), 32'h1);
      check("t5_rst_tick", 32'(tick_1hz), 32'h0);
      btn = '0;
      clks(1);
      rst = 1'b1;
      m_t = 0;
      m_f = 0;

      // 12 h display at 00:xx and 13:xx
      do_reset();
      press(BMid);
      mode12 = 1'b1;
      clks(2);
      check_disp("t6_h0");
      repeat (5) press(BLeft);
      m_f = 5;
      press(BUp);
      model_adj(1'b1);
      press(BRight);
      m_f = 4;
      repeat (3) begin
         press(BUp);
         model_adj(1'b1);
      end
      check_disp("t6_h13");

      // Random edits in EDIT with random display format
      for (int i = 0; i < 40; i++) begin
         mode12 = 1'($urandom_range(0, 1));
         op     = int'($urandom_range(0, 3));
         case (op)
            0: begin press(BLeft);  m_f = (m_f + 1) % 6; end
            1: begin press(BRight); m_f = (m_f + 5) % 6; end
            2: begin press(BUp);    model_adj(1'b1); end
            default: begin press(BDown); model_adj(1'b0); end
         endcase
         check_disp("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
